// File: rtl/uch_ctrl.sv
// Micro-counter controller: sequences an external 4-bit up counter through
// IDLE/RUN/PAUSE/DONE with a selectable-rate prescaler and single-step support.
module uch_ctrl #(
  parameter int DIV_FAST = 4,
  parameter int DIV_SLOW = 8
) (
  input  logic       uchc_clk,
  input  logic       uchc_rst,
  input  logic       uchc_start,
  input  logic       uchc_stop,
  input  logic       uchc_step,
  input  logic       uchc_sel,
  input  logic [3:0] uchc_limit,
  input  logic [3:0] uchc_q,
  output logic       uchc_cnt_en,
  output logic       uchc_cnt_clr,
  output logic [1:0] uchc_state,
  output logic       uchc_done
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  localparam logic [7:0] FAST_M1 = 8'(DIV_FAST - 1);
  localparam logic [7:0] SLOW_M1 = 8'(DIV_SLOW - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] presc_q, presc_d;
  logic       cnt_en_q, cnt_en_d;
  logic       cnt_clr_q, cnt_clr_d;

  logic [7:0] div_m1;
  logic       at_limit;
  logic       presc_wrap;

  always_comb begin
    div_m1     = uchc_sel ? SLOW_M1 : FAST_M1;
    // The counter still holds its old value while the clear strobe is out.
    at_limit   = (uchc_q == uchc_limit) && !cnt_clr_q;
    // ">=" so that a mid-run switch to a shorter period fires at once.
    presc_wrap = (presc_q >= div_m1);

    state_d   = state_q;
    presc_d   = presc_q;
    cnt_en_d  = 1'b0;
    cnt_clr_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!uchc_stop && uchc_start) begin
          state_d   = S_RUN;
          cnt_clr_d = 1'b1;
          presc_d   = 8'd0;
        end
      end
      S_RUN: begin
        if (uchc_stop) begin
          state_d = S_PAUSE;
        end else if (at_limit) begin
          state_d = S_DONE;
        end else if (presc_wrap) begin
          cnt_en_d = 1'b1;
          presc_d  = 8'd0;
        end else begin
          presc_d = presc_q + 8'd1;
        end
      end
      S_PAUSE: begin
        if (uchc_stop) begin
          state_d   = S_IDLE;
          cnt_clr_d = 1'b1;
        end else if (uchc_start) begin
          state_d = S_RUN;
        end else if (uchc_step && !at_limit) begin
          cnt_en_d = 1'b1;
        end
      end
      default: begin
        if (uchc_stop) begin
          state_d = S_IDLE;
        end else if (uchc_start) begin
          state_d   = S_RUN;
          cnt_clr_d = 1'b1;
          presc_d   = 8'd0;
        end
      end
    endcase
  end

  always_ff @(posedge uchc_clk or negedge uchc_rst) begin
    if (!uchc_rst) begin
      state_q   <= S_IDLE;
      presc_q   <= 8'd0;
      cnt_en_q  <= 1'b0;
      cnt_clr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      cnt_en_q  <= cnt_en_d;
      cnt_clr_q <= cnt_clr_d;
    end
  end

  assign uchc_cnt_en  = cnt_en_q;
  assign uchc_cnt_clr = cnt_clr_q;
  assign uchc_state   = state_q;
  assign uchc_done    = (state_q == S_DONE);

endmodule

// File: tb/tb_uch_ctrl.sv
// Bench for uch_ctrl: directed scenarios driving a behavioural 4-bit counter,
// with a cycle-level reference model compared on every falling edge.
module tb_uch_ctrl;

  logic       uchc_clk = 1'b0;
  logic       uchc_rst = 1'b0;
  logic       uchc_start = 1'b0;
  logic       uchc_stop = 1'b0;
  logic       uchc_step = 1'b0;
  logic       uchc_sel = 1'b0;
  logic [3:0] uchc_limit = 4'd5;
  logic [3:0] uchc_q;
  logic       uchc_cnt_en;
  logic       uchc_cnt_clr;
  logic [1:0] uchc_state;
  logic       uchc_done;

  int n_checks = 0;
  int n_err = 0;
  int n_strobe = 0;

  uch_ctrl #(.DIV_FAST(4), .DIV_SLOW(8)) dut (
    .uchc_clk(uchc_clk), .uchc_rst(uchc_rst),
    .uchc_start(uchc_start), .uchc_stop(uchc_stop), .uchc_step(uchc_step),
    .uchc_sel(uchc_sel), .uchc_limit(uchc_limit), .uchc_q(uchc_q),
    .uchc_cnt_en(uchc_cnt_en), .uchc_cnt_clr(uchc_cnt_clr),
    .uchc_state(uchc_state), .uchc_done(uchc_done)
  );

  always #5 uchc_clk = ~uchc_clk;

  // The up counter the controller steers.
  logic [3:0] cnt_reg;
  always @(posedge uchc_clk or negedge uchc_rst) begin
    if (!uchc_rst)         cnt_reg <= 4'd0;
    else if (uchc_cnt_clr) cnt_reg <= 4'd0;
    else if (uchc_cnt_en)  cnt_reg <= cnt_reg + 4'd1;
  end
  assign uchc_q = cnt_reg;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: mode, ticks elapsed in the current period, pending strobes.
  int m_mode = 0;
  int m_ticks = 0;
  int m_count = 0;
  bit m_en = 0;
  bit m_clr = 0;

  initial forever begin
    int div;
    bit n_en, n_clr;
    @(posedge uchc_clk or negedge uchc_rst);
    if (!uchc_rst) begin
      m_mode = 0; m_ticks = 0; m_count = 0; m_en = 0; m_clr = 0;
    end else begin
      div = uchc_sel ? 8 : 4;
      n_en = 0; n_clr = 0;
      case (m_mode)
        0: if (!uchc_stop && uchc_start) begin m_mode = 1; n_clr = 1; m_ticks = 0; end
        1: begin
          if (uchc_stop) m_mode = 2;
          else if (!m_clr && m_count == int'(uchc_limit)) m_mode = 3;
          else if (m_ticks + 1 >= div) begin n_en = 1; m_ticks = 0; end
          else m_ticks = m_ticks + 1;
        end
        2: begin
          if (uchc_stop) begin m_mode = 0; n_clr = 1; end
          else if (uchc_start) m_mode = 1;
          else if (uchc_step && m_count != int'(uchc_limit)) n_en = 1;
        end
        default: begin
          if (uchc_stop) m_mode = 0;
          else if (uchc_start) begin m_mode = 1; n_clr = 1; m_ticks = 0; end
        end
      endcase
      if (m_clr) m_count = 0;
      else if (m_en) m_count = (m_count + 1) % 16;
      m_en = n_en;
      m_clr = n_clr;
    end
  end

  initial forever begin
    @(negedge uchc_clk);
    if (uchc_cnt_en === 1'b1) n_strobe++;
    chk("model_state", 32'(uchc_state), 32'(m_mode));
    chk("model_en", 32'(uchc_cnt_en), 32'(m_en));
    chk("model_clr", 32'(uchc_cnt_clr), 32'(m_clr));
    chk("model_done", 32'(uchc_done), 32'(m_mode == 3));
    chk("model_q", 32'(uchc_q), 32'(m_count));
    chk("en_clr_exclusive", 32'(uchc_cnt_en & uchc_cnt_clr), 32'd0);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge uchc_clk);
    #2;
  endtask

  task automatic wait_state(input logic [1:0] v, input int budget, input string nm);
    int k = 0;
    while (uchc_state !== v && k < budget) begin
      tick(1);
      k++;
    end
    chk(nm, 32'(uchc_state), 32'(v));
  endtask

  task automatic wait_q(input logic [3:0] v, input int budget, input string nm);
    int k = 0;
    while (uchc_q !== v && k < budget) begin
      tick(1);
      k++;
    end
    chk(nm, 32'(uchc_q), 32'(v));
  endtask

  initial begin
    int base;
    tick(3);
    chk("rst_state", 32'(uchc_state), 32'd0);
    chk("rst_en", 32'(uchc_cnt_en), 32'd0);
    chk("rst_clr", 32'(uchc_cnt_clr), 32'd0);
    chk("rst_done", 32'(uchc_done), 32'd0);
    uchc_rst = 1'b1;
    tick(2);

    // Full run to limit 5 at the fast rate.
    uchc_start = 1'b1; tick(1); uchc_start = 1'b0;
    $display("txn: start limit=5 sel=0");
    chk("run_clr_first", 32'(uchc_cnt_clr), 32'd1);
    chk("run_state", 32'(uchc_state), 32'd1);
    tick(29);
    chk("done_state", 32'(uchc_state), 32'd3);
    chk("done_flag", 32'(uchc_done), 32'd1);
    chk("done_q", 32'(uchc_q), 32'd5);
    chk("done_strobes", 32'(n_strobe), 32'd5);
    tick(10);
    chk("no_sixth_strobe", 32'(n_strobe), 32'd5);

    // Pause, hold, single-step, resume.
    uchc_start = 1'b1; tick(1); uchc_start = 1'b0;
    $display("txn: restart from DONE, pause at q=2");
    wait_q(4'd2, 40, "reach_q2");
    uchc_stop = 1'b1; tick(1); uchc_stop = 1'b0;
    chk("pause_state", 32'(uchc_state), 32'd2);
    base = n_strobe;
    tick(20);
    chk("pause_no_strobe", 32'(n_strobe), 32'(base));
    uchc_step = 1'b1; tick(1); uchc_step = 1'b0; tick(3);
    uchc_step = 1'b1; tick(1); uchc_step = 1'b0; tick(3);
    $display("txn: two steps");
    chk("step_q", 32'(uchc_q), 32'd4);
    chk("step_strobes", 32'(n_strobe), 32'(base + 2));
    uchc_start = 1'b1; tick(1); uchc_start = 1'b0;
    wait_state(2'b11, 40, "resume_done");
    chk("resume_q", 32'(uchc_q), 32'd5);
    uchc_stop = 1'b1; tick(1); uchc_stop = 1'b0;
    chk("done_stop_idle", 32'(uchc_state), 32'd0);

    // Rate switch mid-run with prescaler at 6.
    uchc_limit = 4'd15; uchc_sel = 1'b1;
    uchc_start = 1'b1; tick(1); uchc_start = 1'b0;
    tick(6);
    uchc_sel = 1'b0;
    $display("txn: sel 1->0 at prescaler 6");
    tick(1);
    chk("sel_switch_strobe", 32'(uchc_cnt_en), 32'd1);
    tick(4);
    chk("fast_period_strobe", 32'(uchc_cnt_en), 32'd1);

    // Simultaneous request priority.
    uchc_start = 1'b1; uchc_stop = 1'b1; tick(1); uchc_start = 1'b0; uchc_stop = 1'b0;
    $display("txn: start+stop in RUN");
    chk("run_startstop_pause", 32'(uchc_state), 32'd2);
    uchc_stop = 1'b1; uchc_step = 1'b1; tick(1); uchc_stop = 1'b0; uchc_step = 1'b0;
    $display("txn: stop+step in PAUSE");
    chk("pause_stop_idle", 32'(uchc_state), 32'd0);
    chk("pause_stop_clr", 32'(uchc_cnt_clr), 32'd1);
    chk("pause_stop_no_en", 32'(uchc_cnt_en), 32'd0);
    uchc_start = 1'b1; uchc_stop = 1'b1; tick(1); uchc_start = 1'b0; uchc_stop = 1'b0;
    $display("txn: start+stop in IDLE");
    chk("idle_startstop_state", 32'(uchc_state), 32'd0);
    chk("idle_startstop_clr", 32'(uchc_cnt_clr), 32'd0);

    // Asynchronous reset while a strobe is out.
    uchc_start = 1'b1; tick(1); uchc_start = 1'b0;
    tick(4);
    chk("pre_reset_strobe", 32'(uchc_cnt_en), 32'd1);
    uchc_rst = 1'b0;
    #1;
    $display("txn: async reset mid-run");
    chk("areset_state", 32'(uchc_state), 32'd0);
    chk("areset_en", 32'(uchc_cnt_en), 32'd0);
    chk("areset_clr", 32'(uchc_cnt_clr), 32'd0);
    chk("areset_done", 32'(uchc_done), 32'd0);
    tick(2);
    uchc_rst = 1'b1;
    base = n_strobe;
    tick(10);
    chk("post_reset_idle", 32'(uchc_state), 32'd0);
    chk("post_reset_quiet", 32'(n_strobe), 32'(base));

    // limit=0 restart from DONE with q=5.
    uchc_limit = 4'd5;
    uchc_start = 1'b1; tick(1); uchc_start = 1'b0;
    wait_state(2'b11, 40, "lim5_done");
    chk("lim5_q", 32'(uchc_q), 32'd5);
    uchc_limit = 4'd0;
    base = n_strobe;
    uchc_start = 1'b1; tick(1); uchc_start = 1'b0;
    $display("txn: limit=0 restart from DONE");
    chk("lim0_clr_state", 32'(uchc_state), 32'd1);
    chk("lim0_clr", 32'(uchc_cnt_clr), 32'd1);
    chk("lim0_no_false_done", 32'(uchc_done), 32'd0);
    tick(2);
    chk("lim0_done", 32'(uchc_state), 32'd3);
    chk("lim0_q", 32'(uchc_q), 32'd0);
    chk("lim0_no_strobe", 32'(n_strobe), 32'(base));

    tick(3);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/uch_ctrl.md
UCH_CTRL -- requirements
Module: uch_ctrl

Interface
REQ-001 SHALL have parameter DIV_FAST, default 4: prescaler period in clocks when uchc_sel=0; legal range 2..256.
REQ-002 SHALL have parameter DIV_SLOW, default 8: prescaler period in clocks when uchc_sel=1; legal range 2..256.
REQ-003 SHALL have port uchc_clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port uchc_rst, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port uchc_start, input, 1: start/resume request, sampled each edge.
REQ-006 SHALL have port uchc_stop, input, 1: pause/abort request, sampled each edge.
REQ-007 SHALL have port uchc_step, input, 1: single-step request, honoured only in PAUSE.
REQ-008 SHALL have port uchc_sel, input, 1: rate select (0 = DIV_FAST, 1 = DIV_SLOW).
REQ-009 SHALL have port uchc_limit, input, 4: terminal count value.
REQ-010 SHALL have port uchc_q, input, 4: current value fed back from the up counter.
REQ-011 SHALL have port uchc_cnt_en, output, 1: registered one-cycle count-enable strobe to the counter.
REQ-012 SHALL have port uchc_cnt_clr, output, 1: registered one-cycle synchronous clear to the counter.
REQ-013 SHALL have port uchc_state, output, 2: current FSM state encoding.
REQ-014 SHALL have port uchc_done, output, 1: high while in DONE.

Function
REQ-015 SHALL implement states IDLE=00, RUN=01, PAUSE=10, DONE=11, driven on uchc_state.
REQ-016 SHALL resolve simultaneous requests with priority stop > start > step; lower-priority requests in the same cycle are dropped.
REQ-017 IDLE: start -> RUN with uchc_cnt_clr high for the first RUN cycle and prescaler zeroed; stop and step ignored.
REQ-018 RUN: 8-bit prescaler increments each cycle; when it reaches DIV-1 (DIV selected by current uchc_sel), uchc_cnt_en is high the next cycle and prescaler returns to 0.
REQ-019 RUN: if uchc_q == uchc_limit and uchc_cnt_clr is low, next state DONE; no further uchc_cnt_en issued.
REQ-020 SHALL mask the limit compare during any cycle uchc_cnt_clr is high (counter not yet cleared).
REQ-021 RUN: stop -> PAUSE; prescaler value held, no uchc_cnt_en while paused.
REQ-022 PAUSE: start -> RUN, prescaler resumes from held value; stop -> IDLE with uchc_cnt_clr pulsed one cycle.
REQ-023 PAUSE: step with uchc_q != uchc_limit -> uchc_cnt_en high exactly one cycle after the accepting edge; state stays PAUSE; step with uchc_q == uchc_limit ignored.
REQ-024 DONE: uchc_done=1; start -> RUN with uchc_cnt_clr pulse (restart from 0); stop -> IDLE; step ignored.
REQ-025 SHALL treat uchc_sel changes mid-run immediately: if prescaler >= new DIV-1, fire uchc_cnt_en next cycle and wrap to 0.
REQ-026 uchc_cnt_en and uchc_cnt_clr SHALL never be high in the same cycle.
REQ-027 uchc_limit = 0: start -> RUN, clear cycle, then DONE with zero uchc_cnt_en pulses.
REQ-028 uchc_limit and uchc_q are unsigned; no wrap-around past 15 is generated by this block.

Reset
REQ-029 uchc_rst low SHALL immediately force state IDLE, prescaler 0, uchc_cnt_en 0, uchc_cnt_clr 0, uchc_done 0, regardless of clock.
REQ-030 Reset asserted mid-operation SHALL abort without emitting a further strobe; first post-reset action requires a new start.

Verification (DIV_FAST=4, DIV_SLOW=8, behavioural 4-bit up counter on the outputs)
REQ-031 Reset, sel=0, limit=5, pulse start -> one clr cycle, uchc_cnt_en every 4 clocks, q reaches 5 after 5 strobes, state=11, done=1, no 6th strobe.
REQ-032 Run to q=2, pulse stop -> state=10, no strobes for 20 clocks; step twice -> exactly two strobes, q=4; start -> strobes resume, DONE at q=5.
REQ-033 sel=1 running, prescaler at 6, switch sel=0 -> strobe next cycle, then period 4 clocks.
REQ-034 start+stop same cycle in RUN -> PAUSE; in IDLE -> stays IDLE, no clr; stop+step in PAUSE -> IDLE with clr pulse, no strobe.
REQ-035 Drop uchc_rst between edges in RUN -> all outputs 0 and state=00 before next edge; release, no activity until start.
REQ-036 limit=0, start from DONE with q=5 -> clr pulse, no false DONE during clr cycle, DONE next, zero strobes.
